// File: rtl/enc8to3_ser_pkg.sv
// Shared definitions for the serializing 8-to-3 encoder.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
//
// Contents: FSM state enum, bus widths, population-count helper.
package enc_pkg;

  localparam int ENC_IN_W  = 8;
  localparam int ENC_OUT_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } enc_state_e;

  // Number of set bits in a request vector (0..8, hence 4 bits).
  function automatic logic [3:0] popcnt8(input logic [ENC_IN_W-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < ENC_IN_W; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/enc8to3_ser_prio.sv
// Combinational 8-to-3 priority encoder.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input.
//
// Ports:
//   in   [7:0] : request lines
//   code [2:0] : index of the winning set bit (0 when none set)
//   any        : at least one request line is set
// Parameter LSB_FIRST: 1 -> lowest set index wins, 0 -> highest set index wins.
module prio_enc8to3
  import enc_pkg::*;
#(
  parameter int LSB_FIRST = 1
) (
  input  logic [ENC_IN_W-1:0]  in,
  output logic [ENC_OUT_W-1:0] code,
  output logic                 any
);

  // Scan in the direction opposite to the priority so the winning bit is
  // the last one written.
  always_comb begin
    code = '0;
    if (LSB_FIRST != 0) begin
      for (int i = ENC_IN_W - 1; i >= 0; i--) begin
        if (in[i]) code = ENC_OUT_W'(i);
      end
    end else begin
      for (int i = 0; i < ENC_IN_W; i++) begin
        if (in[i]) code = ENC_OUT_W'(i);
      end
    end
  end

  assign any = |in;

endmodule

// File: rtl/enc8to3_ser.sv
// Serializing 8-to-3 encoder: emits the index of every set bit of a captured vector.
// Latency: first code 1 cycle after capture; one code per cycle with out_rdy high.
// Backpressure: out/out_vld held stable while out_rdy is low; in_rdy low during SEND.
//
// Ports:
//   clk, rst (sync, active-high)
//   in[7:0], en, load, in_rdy   : capture side (accepted on load & en & in_rdy)
//   out[2:0], out_vld, out_rdy  : code stream
//   done                        : one-cycle pulse once the vector is drained
//   busy                        : registered "in SEND"
//   cnt[3:0] (ENC8TO3_CNT_EN)   : popcount of the last captured vector
// Optional feature macro: ENC8TO3_CNT_EN.
module enc8to3_ser
  import enc_pkg::*;
#(
  parameter int LSB_FIRST = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ENC_IN_W-1:0]  in,
  input  logic                 en,
  input  logic                 load,
  output logic                 in_rdy,
  output logic [ENC_OUT_W-1:0] out,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic                 done,
  output logic                 busy
`ifdef ENC8TO3_CNT_EN
  ,output logic [3:0]          cnt
`endif
);

  enc_state_e           state_q, state_d;
  logic [ENC_IN_W-1:0]  pend_q, pend_d;
  logic [ENC_OUT_W-1:0] out_q, out_d;
  logic                 out_vld_q, out_vld_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 cap;
  logic [ENC_OUT_W-1:0] nxt_code;
  logic                 nxt_any;

  assign in_rdy = (state_q == IDLE);
  assign cap    = load & en & in_rdy;

  // Pending bits after this edge. In SEND, out_q always holds the priority
  // index of pend_q, so it names the bit being handed off.
  always_comb begin
    pend_d = pend_q;
    case (state_q)
      IDLE: if (cap) pend_d = in;
      SEND: if (out_rdy) pend_d = pend_q & ~(ENC_IN_W'(1) << out_q);
      default: pend_d = pend_q;
    endcase
  end

  // Encoding the next pending set lets out be registered with no extra
  // cycle of latency.
  prio_enc8to3 #(
    .LSB_FIRST (LSB_FIRST)
  ) u_prio (
    .in   (pend_d),
    .code (nxt_code),
    .any  (nxt_any)
  );

  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    out_vld_d = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cap) begin
          if (nxt_any) begin
            state_d   = SEND;
            out_vld_d = 1'b1;
            out_d     = nxt_code;
          end else begin
            // Empty vector: nothing to emit, report drained immediately.
            done_d = 1'b1;
          end
        end
      end
      SEND: begin
        out_vld_d = 1'b1;
        if (out_rdy) begin
          if (nxt_any) begin
            out_d = nxt_code;
          end else begin
            // Last bit handed off; out keeps its final value.
            state_d   = IDLE;
            out_vld_d = 1'b0;
            done_d    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_d = (state_d == SEND);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign out     = out_q;
  assign out_vld = out_vld_q;
  assign done    = done_q;
  assign busy    = busy_q;

`ifdef ENC8TO3_CNT_EN
  logic [3:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cap) begin
      cnt_q <= popcnt8(in);
    end
  end

  assign cnt = cnt_q;
`endif

endmodule

// File: tb/tb_enc8to3_ser.sv
module tb_enc8to3_ser;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, load, out_rdy;
  logic [7:0] in_v;
  logic       rdy_l, rdy_m, vld_l, vld_m, done_l, done_m, busy_l, busy_m;
  logic [2:0] out_l, out_m;
`ifdef ENC8TO3_CNT_EN
  logic [3:0] cnt_l, cnt_m;
`endif

  enc8to3_ser #(.LSB_FIRST(1)) dut_l (
    .clk(clk), .rst(rst), .in(in_v), .en(en), .load(load), .in_rdy(rdy_l),
    .out(out_l), .out_vld(vld_l), .out_rdy(out_rdy), .done(done_l), .busy(busy_l)
`ifdef ENC8TO3_CNT_EN
    , .cnt(cnt_l)
`endif
  );

  enc8to3_ser #(.LSB_FIRST(0)) dut_m (
    .clk(clk), .rst(rst), .in(in_v), .en(en), .load(load), .in_rdy(rdy_m),
    .out(out_m), .out_vld(vld_m), .out_rdy(out_rdy), .done(done_m), .busy(busy_m)
`ifdef ENC8TO3_CNT_EN
    , .cnt(cnt_m)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the remaining indices of the captured vector, listed in
  // emission order for each priority direction.
  int rem_l[$];
  int rem_m[$];
  int hold_l = 0, hold_m = 0;
  bit m_done = 0;
  int m_cnt  = 0;
  bit m_init = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        rem_l.delete();
        rem_m.delete();
        hold_l = 0;
        hold_m = 0;
        m_done = 0;
        m_cnt  = 0;
        m_init = 1;
      end else begin
        m_done = 0;
        if (rem_l.size() == 0) begin
          if (load && en) begin
            m_cnt = 0;
            for (int i = 0; i < 8; i++) begin
              if (in_v[i]) begin
                rem_l.push_back(i);
                rem_m.push_front(i);
                m_cnt++;
              end
            end
            if (m_cnt == 0) m_done = 1;
          end
        end else if (out_rdy) begin
          hold_l = rem_l.pop_front();
          hold_m = rem_m.pop_front();
          if (rem_l.size() == 0) m_done = 1;
        end
      end
    end
  end

  // Per-cycle comparison of both DUTs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (m_init) begin
        chk("vld_l",  32'(vld_l),  32'(rem_l.size() != 0));
        chk("vld_m",  32'(vld_m),  32'(rem_m.size() != 0));
        chk("out_l",  32'(out_l),  (rem_l.size() != 0) ? rem_l[0] : hold_l);
        chk("out_m",  32'(out_m),  (rem_m.size() != 0) ? rem_m[0] : hold_m);
        chk("done_l", 32'(done_l), 32'(m_done));
        chk("done_m", 32'(done_m), 32'(m_done));
        chk("busy_l", 32'(busy_l), 32'(rem_l.size() != 0));
        chk("busy_m", 32'(busy_m), 32'(rem_m.size() != 0));
        chk("rdy_l",  32'(rdy_l),  32'(rem_l.size() == 0));
        chk("rdy_m",  32'(rdy_m),  32'(rem_m.size() == 0));
`ifdef ENC8TO3_CNT_EN
        chk("cnt_l",  32'(cnt_l),  m_cnt);
        chk("cnt_m",  32'(cnt_m),  m_cnt);
`endif
      end
    end
  end

  // Directed scenarios with hand-computed expectations, then random traffic.
  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; out_rdy = 1'b1; in_v = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_in_rdy", 32'(rdy_l), 32'd1);
    chk("rst_vld",    32'(vld_l), 32'd0);
    chk("rst_out",    32'(out_l), 32'd0);
    chk("rst_done",   32'(done_l), 32'd0);
    chk("rst_busy",   32'(busy_l), 32'd0);
    #2 rst = 1'b0;

    // 8'b1010_0100: LSB-first 2,5,7; MSB-first 7,5,2; then done.
    in_v = 8'hA4; en = 1'b1; load = 1'b1; out_rdy = 1'b1;
    @(negedge clk);
    chk("a4_c1_l", 32'(out_l), 32'd2);
    chk("a4_c1_m", 32'(out_m), 32'd7);
    chk("a4_c1_vld", 32'(vld_l), 32'd1);
    chk("a4_c1_rdy", 32'(rdy_l), 32'd0);
    #2 load = 1'b0; en = 1'b0;
    @(negedge clk);
    chk("a4_c2_l", 32'(out_l), 32'd5);
    chk("a4_c2_m", 32'(out_m), 32'd5);
    @(negedge clk);
    chk("a4_c3_l", 32'(out_l), 32'd7);
    chk("a4_c3_m", 32'(out_m), 32'd2);
    @(negedge clk);
    chk("a4_done", 32'(done_l), 32'd1);
    chk("a4_vld0", 32'(vld_l), 32'd0);
    chk("a4_rdy1", 32'(rdy_l), 32'd1);
    chk("a4_hold", 32'(out_l), 32'd7);

    // Backpressure on 8'h81.
    #2 in_v = 8'h81; en = 1'b1; load = 1'b1; out_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_out", 32'(out_l), 32'd0);
      chk("bp_vld", 32'(vld_l), 32'd1);
      #2 load = 1'b0; en = 1'b0;
    end
    out_rdy = 1'b1;
    @(negedge clk);
    chk("bp_out7", 32'(out_l), 32'd7);
    @(negedge clk);
    chk("bp_done", 32'(done_l), 32'd1);

    // Zero vector.
    #2 in_v = 8'h00; en = 1'b1; load = 1'b1;
    @(negedge clk);
    chk("z_done", 32'(done_l), 32'd1);
    chk("z_vld",  32'(vld_l), 32'd0);
    #2 load = 1'b0; en = 1'b0;
    @(negedge clk);
    chk("z_done0", 32'(done_l), 32'd0);

    // load with en=0 is not captured.
    #2 in_v = 8'h3C; en = 1'b0; load = 1'b1;
    @(negedge clk);
    chk("en0_vld", 32'(vld_l), 32'd0);
    chk("en0_rdy", 32'(rdy_l), 32'd1);
    #2 load = 1'b0;

    // load of 8'hFF during SEND of 8'h03 is ignored.
    in_v = 8'h03; en = 1'b1; load = 1'b1;
    @(negedge clk);
    chk("ign_c0", 32'(out_l), 32'd0);
    #2 in_v = 8'hFF;
    @(negedge clk);
    chk("ign_c1", 32'(out_l), 32'd1);
    @(negedge clk);
    chk("ign_done", 32'(done_l), 32'd1);
    chk("ign_vld0", 32'(vld_l), 32'd0);
    #2 load = 1'b0; en = 1'b0;
    @(negedge clk);
    chk("ign_idle", 32'(vld_l), 32'd0);

    // Reset after the first handshake of 8'hF0.
    #2 in_v = 8'hF0; en = 1'b1; load = 1'b1;
    @(negedge clk);
    chk("f0_c0", 32'(out_l), 32'd4);
`ifdef ENC8TO3_CNT_EN
    chk("f0_cnt", 32'(cnt_l), 32'd4);
`endif
    #2 load = 1'b0; en = 1'b0;
    @(negedge clk);
    chk("f0_c1", 32'(out_l), 32'd5);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("mrst_vld",  32'(vld_l), 32'd0);
    chk("mrst_done", 32'(done_l), 32'd0);
    chk("mrst_rdy",  32'(rdy_l), 32'd1);
    chk("mrst_out",  32'(out_l), 32'd0);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("mrst_nodone", 32'(done_l), 32'd0);

    // Full vector: eight codes in eight cycles, then done.
    #2 in_v = 8'hFF; en = 1'b1; load = 1'b1;
    @(negedge clk);
`ifdef ENC8TO3_CNT_EN
    chk("ff_cnt", 32'(cnt_l), 32'd8);
`endif
    #2 load = 1'b0; en = 1'b0;
    repeat (8) @(negedge clk);
    chk("ff_done", 32'(done_l), 32'd1);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 600; c++) begin
      #2;
      en      = ($urandom_range(0, 3) != 0);
      load    = ($urandom_range(0, 2) == 0);
      in_v    = 8'($urandom);
      if ($urandom_range(0, 3) == 0) in_v = in_v & 8'($urandom);
      out_rdy = ($urandom_range(0, 3) != 0);
      rst     = ($urandom_range(0, 60) == 0);
      @(negedge clk);
    end

    #2 rst = 1'b0; load = 1'b0; en = 1'b0; out_rdy = 1'b1;
    repeat (12) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
